mc_datapath_regs: RTL

- Architectural and non-architectural register stage of the multi-cycle MIPS datapath: PC, IR, MDR, A, B and ALUOut, plus the steering muxes around them.
- Sits directly upstream of the multi-cycle controller. It supplies op/funct from the IR and takes back the controller's enables and selects.
- Feeds the ALU, the register file and the unified instruction/data memory.

---
 rtl/mc_datapath_regs.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mc_datapath_regs.sv
// -----------------------------------------------------------------------------
// mc_datapath_regs
//
// Register stage of the multi-cycle MIPS datapath. Holds the architectural PC
// and the non-architectural IR, MDR, A, B and ALUOut registers, together with
// the steering muxes that feed the ALU, the register file and the unified
// instruction/data memory. The multi-cycle controller sits directly
// downstream of op/funct and drives every enable and select back into here.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   pcen       PC write enable
//   irwrite    IR write enable
//   iord       memory address select (0 = PC, 1 = ALUOut)
//   alusrca    SrcA select (0 = PC, 1 = A)
//   alusrcb    SrcB select (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2)
//   pcsrc      next-PC select (00 = aluresult, 01 = ALUOut, 10 = jump, 11 = hold)
//   regdst     write-register select (0 = rt, 1 = rd)
//   memtoreg   write-data select (0 = ALUOut, 1 = MDR)
//   readdata   memory read data
//   rd1, rd2   register file read data (rs, rt)
//   aluresult  combinational ALU result
//   adr        memory address
//   writedata  memory write data (B register)
//   srca/srcb  ALU operands
//   op, funct  instruction fields to the controller
//   ra1, ra2   register file read addresses (rs, rt)
//   wa3, wd3   register file write address and data
//   pc         current PC
// -----------------------------------------------------------------------------
module mc_datapath_regs #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             irwrite,
  input  logic             iord,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       pcsrc,
  input  logic             regdst,
  input  logic             memtoreg,
  input  logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] aluresult,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mdr_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] aluout_q;

  logic [WIDTH-1:0] pcnext;
  logic [WIDTH-1:0] signimm;
  logic [WIDTH-1:0] signimm_sh2;
  logic [WIDTH-1:0] jump_target;

  // PC and IR are the only enabled registers; the rest are free-running
  // one-cycle pipeline latches between multi-cycle steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      if (pcen)    pc_q <= pcnext;
      if (irwrite) ir_q <= readdata;
      mdr_q    <= readdata;
      a_q      <= rd1;
      b_q      <= rd2;
      aluout_q <= aluresult;
    end
  end

  assign signimm     = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  // Top two bits fall off; branch offsets are not saturated.
  assign signimm_sh2 = {signimm[WIDTH-3:0], 2'b00};
  // Upper nibble comes from the PC already advanced in the fetch cycle.
  assign jump_target = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};

  always_comb begin
    pcnext = pc_q;
    unique case (pcsrc)
      2'b00:   pcnext = aluresult;
      2'b01:   pcnext = aluout_q;
      2'b10:   pcnext = jump_target;
      default: pcnext = pc_q;
    endcase
  end

  always_comb begin
    srcb = b_q;
    unique case (alusrcb)
      2'b00:   srcb = b_q;
      2'b01:   srcb = WIDTH'(4);
      2'b10:   srcb = signimm;
      default: srcb = signimm_sh2;
    endcase
  end

  assign srca      = alusrca  ? a_q      : pc_q;
  assign adr       = iord     ? aluout_q : pc_q;
  assign wd3       = memtoreg ? mdr_q    : aluout_q;
  assign wa3       = regdst   ? ir_q[15:11] : ir_q[20:16];

  assign writedata = b_q;
  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign ra1       = ir_q[25:21];
  assign ra2       = ir_q[20:16];
  assign pc        = pc_q;

endmodule
